// File: rtl/hd44780_lcd_rx_if.sv
// Received-byte stream from the HD44780 bus receiver to its consumer.
// The master side (receiver) presents the FIFO head; the slave side accepts it.
interface hd44780_lcd_rx_if;
    logic       o_valid;
    logic [7:0] o_byte;
    logic       o_rs;
    logic       i_ready;

    modport master (
        output o_valid,
        output o_byte,
        output o_rs,
        input  i_ready
    );

    modport slave (
        input  o_valid,
        input  o_byte,
        input  o_rs,
        output i_ready
    );
endinterface

// File: rtl/hd44780_lcd_rx.sv
// HD44780 bus snooper: samples the asynchronous RS/E/D7..D4 lines of an
// HD44780-style LCD bus, rebuilds command/data bytes in 8-bit or 4-bit
// interface mode, and queues them with their RS bit in a small FIFO.
module hd44780_lcd_rx #(
    parameter int SYNC_STAGES  = 2,
    parameter int E_MIN_CYCLES = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_lcd_rs,
    input  logic                   i_lcd_e,
    input  logic [3:0]             i_lcd_data,
    hd44780_lcd_rx_if.master       rx,
    output logic                   o_mode4,
    output logic                   o_overflow,
    output logic                   o_glitch
);

    localparam int         PTR_W   = $clog2(FIFO_DEPTH);
    localparam int         CNT_W   = PTR_W + 1;
    localparam logic [7:0] E_MIN_C = 8'(E_MIN_CYCLES);

    typedef enum logic {
        HI_WAIT = 1'b0,
        LO_WAIT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers: bit 5 = RS, bit 4 = E, bits 3:0 = D7..D4
    // ------------------------------------------------------------------
    logic [5:0] sync_q [SYNC_STAGES];
    logic       s_rs_s;
    logic       s_e_s;
    logic [3:0] s_d_s;

    // Shift the raw bus lines through the synchronizer chain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 6'd0;
            end
        end else begin
            sync_q[0] <= {i_lcd_rs, i_lcd_e, i_lcd_data};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s_rs_s = sync_q[SYNC_STAGES-1][5];
    assign s_e_s  = sync_q[SYNC_STAGES-1][4];
    assign s_d_s  = sync_q[SYNC_STAGES-1][3:0];

    // ------------------------------------------------------------------
    // E-pulse measurement and strobe qualification
    // ------------------------------------------------------------------
    logic       e_prev_q;
    logic [7:0] e_cnt_q;
    logic       last_rs_q;
    logic [3:0] last_d_q;
    logic       strobe_s;
    logic       accept_s;
    logic       glitch_s;

    // Track E history, the high-time count and the bus values of the last E-high cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            e_prev_q  <= 1'b0;
            e_cnt_q   <= 8'd0;
            last_rs_q <= 1'b0;
            last_d_q  <= 4'd0;
        end else begin
            e_prev_q <= s_e_s;
            if (s_e_s) begin
                e_cnt_q   <= (e_cnt_q == 8'hFF) ? 8'hFF : (e_cnt_q + 8'd1);
                last_rs_q <= s_rs_s;
                last_d_q  <= s_d_s;
            end else begin
                e_cnt_q <= 8'd0;
            end
        end
    end

    assign strobe_s = e_prev_q & ~s_e_s;
    assign accept_s = strobe_s & (e_cnt_q >= E_MIN_C);
    assign glitch_s = strobe_s & ~accept_s;

    // ------------------------------------------------------------------
    // Byte assembly FSM (8-bit direct, 4-bit high/low nibble pairing)
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic       mode4_q, mode4_d;
    logic [3:0] hi_nib_q, hi_nib_d;
    logic       hi_rs_q, hi_rs_d;
    logic       cmp_valid_d;
    logic [7:0] cmp_byte_d;
    logic       cmp_rs_d;
    logic       push_q;
    logic [7:0] push_byte_q;
    logic       push_rs_q;
    logic       glitch_q;

    // Decide the next nibble state, mode and any completed byte for this cycle.
    always_comb begin
        state_d     = state_q;
        mode4_d     = mode4_q;
        hi_nib_d    = hi_nib_q;
        hi_rs_d     = hi_rs_q;
        cmp_valid_d = 1'b0;
        cmp_byte_d  = 8'h00;
        cmp_rs_d    = 1'b0;
        if (accept_s) begin
            if (!mode4_q) begin
                cmp_valid_d = 1'b1;
                cmp_byte_d  = {last_d_q, 4'b0000};
                cmp_rs_d    = last_rs_q;
                if (!last_rs_q && (last_d_q == 4'b0010)) begin
                    mode4_d = 1'b1;
                    state_d = HI_WAIT;
                end else begin
                    mode4_d = mode4_q;
                end
            end else begin
                case (state_q)
                    HI_WAIT: begin
                        hi_nib_d = last_d_q;
                        hi_rs_d  = last_rs_q;
                        state_d  = LO_WAIT;
                    end
                    LO_WAIT: begin
                        cmp_valid_d = 1'b1;
                        cmp_byte_d  = {hi_nib_q, last_d_q};
                        cmp_rs_d    = hi_rs_q;
                        state_d     = HI_WAIT;
                        if (!hi_rs_q && (hi_nib_q == 4'b0011)) begin
                            mode4_d = 1'b0;
                        end else begin
                            mode4_d = mode4_q;
                        end
                    end
                    default: begin
                        state_d = HI_WAIT;
                    end
                endcase
            end
        end else begin
            state_d = state_q;
        end
    end

    // Hold FSM state, completed-byte staging register and the sticky glitch flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= HI_WAIT;
            mode4_q     <= 1'b0;
            hi_nib_q    <= 4'd0;
            hi_rs_q     <= 1'b0;
            push_q      <= 1'b0;
            push_byte_q <= 8'h00;
            push_rs_q   <= 1'b0;
            glitch_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode4_q     <= mode4_d;
            hi_nib_q    <= hi_nib_d;
            hi_rs_q     <= hi_rs_d;
            push_q      <= cmp_valid_d;
            push_byte_q <= cmp_byte_d;
            push_rs_q   <= cmp_rs_d;
            glitch_q    <= glitch_q | glitch_s;
        end
    end

    // ------------------------------------------------------------------
    // Received-byte FIFO with registered head outputs
    // ------------------------------------------------------------------
    logic [8:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_s;
    logic             pop_s;
    logic             push_ok_s;
    logic             ovf_s;
    logic [8:0]       head_d;
    logic             valid_q;
    logic [7:0]       byte_q;
    logic             rs_q;
    logic             ovf_q;

    // Work out occupancy, pointers and the next head entry, bypassing a write into an empty slot.
    always_comb begin
        full_s    = (count_q == CNT_W'(FIFO_DEPTH));
        pop_s     = valid_q & rx.i_ready;
        push_ok_s = push_q & (~full_s | pop_s);
        ovf_s     = push_q & full_s & ~pop_s;
        count_d   = count_q + CNT_W'(push_ok_s) - CNT_W'(pop_s);
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop_s);
        wr_ptr_d  = wr_ptr_q + PTR_W'(push_ok_s);
        head_d    = 9'd0;
        if (count_d == CNT_W'(0)) begin
            head_d = 9'd0;
        end else if (push_ok_s && (rd_ptr_d == wr_ptr_q)) begin
            head_d = {push_rs_q, push_byte_q};
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // Update FIFO storage, pointers, registered head and the sticky overflow flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 9'd0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            byte_q   <= 8'h00;
            rs_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= {push_rs_q, push_byte_q};
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= (count_d != CNT_W'(0));
            byte_q   <= head_d[7:0];
            rs_q     <= head_d[8];
            ovf_q    <= ovf_q | ovf_s;
        end
    end

    assign rx.o_valid = valid_q;
    assign rx.o_byte  = byte_q;
    assign rx.o_rs    = rs_q;
    assign o_mode4    = mode4_q;
    assign o_overflow = ovf_q;
    assign o_glitch   = glitch_q;

endmodule

// File: tb/tb_hd44780_lcd_rx.sv
// Self-checking bench for hd44780_lcd_rx: directed vector table, hand-written
// latency/overflow/reset sequences, and random strobes checked against a
// byte-level reference model of the LCD interface protocol.
module tb_hd44780_lcd_rx;

    localparam int SYNC  = 2;
    localparam int EMIN  = 8;
    localparam int DEPTH = 4;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       lcd_rs = 1'b0;
    logic       lcd_e  = 1'b0;
    logic [3:0] lcd_d  = 4'd0;
    logic       mode4;
    logic       ovf;
    logic       glitch;

    hd44780_lcd_rx_if rx_if ();

    hd44780_lcd_rx #(
        .SYNC_STAGES (SYNC),
        .E_MIN_CYCLES(EMIN),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_lcd_rs  (lcd_rs),
        .i_lcd_e   (lcd_e),
        .i_lcd_data(lcd_d),
        .rx        (rx_if),
        .o_mode4   (mode4),
        .o_overflow(ovf),
        .o_glitch  (glitch)
    );

    always #5 clk = ~clk;

    int         checks    = 0;
    int         failures  = 0;
    int         rdy_mode  = 0;
    int         pop_count = 0;
    logic [8:0] last_pop  = 9'd0;
    logic [8:0] exp_q [$];

    // reference model state (protocol level)
    logic       m_mode4;
    logic       m_have_hi;
    logic [3:0] m_hi;
    logic       m_hi_rs;
    logic       m_glitch;
    logic       m_ovf;

    typedef struct {
        logic       rs;
        logic [3:0] d;
        int         w;
        logic       push;
        logic [7:0] b;
        logic       brs;
        logic       mode4;
        logic       glitch;
    } row_t;

    row_t tbl [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reset();
        m_mode4   = 1'b0;
        m_have_hi = 1'b0;
        m_hi      = 4'd0;
        m_hi_rs   = 1'b0;
        m_glitch  = 1'b0;
        m_ovf     = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_emit(input logic [7:0] b, input logic rs);
        if (exp_q.size() >= DEPTH) m_ovf = 1'b1;
        else exp_q.push_back({rs, b});
    endtask

    // Protocol-level view: a strobe of w E-high cycles either is a glitch,
    // a full 8-bit transfer, or one half of a 4-bit pair.
    task automatic model_strobe(input logic rs, input logic [3:0] d, input int w);
        if (w < EMIN) begin
            m_glitch = 1'b1;
        end else if (!m_mode4) begin
            model_emit({d, 4'h0}, rs);
            if (rs == 1'b0 && d == 4'h2) begin
                m_mode4   = 1'b1;
                m_have_hi = 1'b0;
            end
        end else if (!m_have_hi) begin
            m_hi      = d;
            m_hi_rs   = rs;
            m_have_hi = 1'b1;
        end else begin
            model_emit({m_hi, d}, m_hi_rs);
            m_have_hi = 1'b0;
            if (m_hi_rs == 1'b0 && m_hi == 4'h3) m_mode4 = 1'b0;
        end
    endtask

    task automatic lcd_strobe(input logic rs, input logic [3:0] d, input int w);
        model_strobe(rs, d, w);
        lcd_rs = rs;
        lcd_d  = d;
        tick(1);
        lcd_e = 1'b1;
        tick(w);
        lcd_e = 1'b0;
        tick(5);
    endtask

    task automatic chk_reset_state();
        chk("rst_valid",  rx_if.o_valid, 0);
        chk("rst_byte",   rx_if.o_byte,  0);
        chk("rst_rs",     rx_if.o_rs,    0);
        chk("rst_mode4",  mode4,         0);
        chk("rst_ovf",    ovf,           0);
        chk("rst_glitch", glitch,        0);
    endtask

    initial begin
        logic       hold_prev;
        logic [8:0] prev_head;
        int         pc;
        hold_prev = 1'b0;
        prev_head = 9'd0;
        model_reset();

        tbl[0]  = '{1'b0, 4'h3, 10, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 4'h3, 10, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 4'h3, 10, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 4'h2, 10, 1'b1, 8'h20, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 4'h4, 10, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 4'h1, 10, 1'b1, 8'h41, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 4'h5,  3, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 4'h6, 10, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 4'h5, 10, 1'b1, 8'h65, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 4'h7, EMIN-1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 4'h7, EMIN,   1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{1'b1, 4'h3, EMIN,   1'b1, 8'h73, 1'b1, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 4'h3, 10, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 4'h8, 10, 1'b1, 8'h38, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b1, 4'hC, 10, 1'b1, 8'hC0, 1'b1, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 4'h2,  9, 1'b1, 8'h20, 1'b0, 1'b1, 1'b1};

        fork
            // consumer ready driver
            begin
                rx_if.i_ready = 1'b0;
                forever begin
                    @(posedge clk);
                    #1;
                    case (rdy_mode)
                        0:       rx_if.i_ready = 1'b0;
                        1:       rx_if.i_ready = 1'b1;
                        default: rx_if.i_ready = 1'($urandom_range(0, 1));
                    endcase
                end
            end
            // output monitor / scoreboard
            begin
                forever begin
                    @(negedge clk);
                    if (rst_n) begin
                        if (hold_prev) begin
                            chk("hold_valid", rx_if.o_valid, 1);
                            chk("hold_data", {rx_if.o_rs, rx_if.o_byte}, prev_head);
                        end
                        if (rx_if.o_valid) begin
                            if (rx_if.i_ready) begin
                                if (exp_q.size() == 0) begin
                                    checks++;
                                    failures++;
                                    $display("FAIL unexpected_pop actual=%0h required=none",
                                             {rx_if.o_rs, rx_if.o_byte});
                                end else begin
                                    chk("pop_byte", {rx_if.o_rs, rx_if.o_byte}, exp_q.pop_front());
                                end
                                pop_count++;
                                last_pop = {rx_if.o_rs, rx_if.o_byte};
                            end
                        end else begin
                            chk("idle_zero", {rx_if.o_rs, rx_if.o_byte}, 0);
                        end
                        hold_prev = rx_if.o_valid & ~rx_if.i_ready;
                        prev_head = {rx_if.o_rs, rx_if.o_byte};
                    end else begin
                        hold_prev = 1'b0;
                    end
                end
            end
        join_none

        // reset state
        tick(3);
        chk_reset_state();
        rst_n = 1'b1;
        rdy_mode = 1;
        tick(SYNC + 2);

        // directed vector table (init, 4-bit data, glitch, E width boundary, mode back)
        for (int i = 0; i < 16; i++) begin
            pc = pop_count;
            lcd_strobe(tbl[i].rs, tbl[i].d, tbl[i].w);
            tick(4);
            if (tbl[i].push) begin
                chk("row_pushcnt", pop_count - pc, 1);
                chk("row_byte", last_pop, {tbl[i].brs, tbl[i].b});
            end else begin
                chk("row_nopush", pop_count - pc, 0);
            end
            chk("row_mode4", mode4, tbl[i].mode4);
            chk("row_glitch", glitch, tbl[i].glitch);
        end

        // latency: o_valid exactly two cycles after the completing strobe cycle
        rdy_mode = 0;
        tick(3);
        lcd_strobe(1'b1, 4'h4, 10);
        lcd_rs = 1'b1;
        lcd_d  = 4'h1;
        tick(1);
        lcd_e = 1'b1;
        tick(10);
        model_strobe(1'b1, 4'h1, 10);
        lcd_e = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("lat_valid", rx_if.o_valid, (k == 4) ? 1 : 0);
        end
        chk("lat_byte", rx_if.o_byte, 8'h41);
        chk("lat_rs", rx_if.o_rs, 1);
        tick(4);
        pc = pop_count;
        rdy_mode = 1;
        tick(6);
        chk("lat_popped", pop_count - pc, 1);

        // overflow: five bytes into a four-entry FIFO with no consumer
        rdy_mode = 0;
        tick(2);
        for (int i = 1; i <= 5; i++) begin
            lcd_strobe(1'b1, 4'(i), 10);
            lcd_strobe(1'b1, 4'(i), 10);
        end
        tick(4);
        chk("ovf_flag", ovf, 1);
        chk("ovf_head", {rx_if.o_rs, rx_if.o_byte}, 9'h111);
        pc = pop_count;
        rdy_mode = 1;
        tick(12);
        chk("ovf_popcnt", pop_count - pc, 4);
        chk("ovf_last", last_pop, 9'h144);
        chk("ovf_empty", rx_if.o_valid, 0);
        chk("ovf_sticky", ovf, 1);

        // reset in the middle of a 4-bit byte
        lcd_strobe(1'b1, 4'h7, 10);
        rst_n = 1'b0;
        model_reset();
        tick(2);
        chk_reset_state();
        rst_n = 1'b1;
        tick(SYNC + 2);
        pc = pop_count;
        lcd_strobe(1'b0, 4'h3, 10);
        lcd_strobe(1'b0, 4'h2, 10);
        tick(4);
        chk("rstmid_popcnt", pop_count - pc, 2);
        chk("rstmid_last", last_pop, 9'h020);
        chk("rstmid_mode4", mode4, 1);

        // random strobes against the reference model, random consumer stalls
        rdy_mode = 2;
        for (int i = 0; i < 150; i++) begin
            lcd_strobe(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                       int'($urandom_range(4, 14)));
        end
        rdy_mode = 1;
        tick(20);
        chk("rnd_drained", exp_q.size(), 0);
        chk("rnd_mode4", mode4, m_mode4);
        chk("rnd_glitch", glitch, m_glitch);
        chk("rnd_ovf", ovf, m_ovf);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hd44780_lcd_rx.md
HD44780_LCD_RX -- requirements
Module: hd44780_lcd_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flip-flop synchronizer stages on lcd_rs, lcd_e and lcd_data inputs (legal 2..4).
REQ-002 SHALL have parameter E_MIN_CYCLES, default 8, minimum synchronized E-high width in i_clk cycles for a strobe to be accepted (legal 1..255).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, received-byte FIFO entries (power of two, 2..16).
REQ-004 SHALL have port i_clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port i_lcd_rs  input  1  LCD register-select line (0 = command, 1 = data), asynchronous to i_clk.
REQ-007 SHALL have port i_lcd_e  input  1  LCD enable strobe, asynchronous; transfer occurs on falling edge.
REQ-008 SHALL have port i_lcd_data  input  4  LCD D7..D4, asynchronous.
REQ-009 SHALL have port o_valid  output  1  FIFO head holds a received byte.
REQ-010 SHALL have port o_byte  output  8  byte at FIFO head.
REQ-011 SHALL have port o_rs  output  1  RS value captured with the byte at FIFO head.
REQ-012 SHALL have port i_ready  input  1  consumer accepts head when o_valid and i_ready both high.
REQ-013 SHALL have port o_mode4  output  1  1 = receiver in 4-bit interface mode, 0 = 8-bit mode.
REQ-014 SHALL have port o_overflow  output  1  sticky: byte completed while FIFO full.
REQ-015 SHALL have port o_glitch  output  1  sticky: E-high pulse shorter than E_MIN_CYCLES seen.

Function
REQ-016 SHALL pass all three inputs through SYNC_STAGES synchronizers; all behaviour below uses synchronized values only.
REQ-017 SHALL count consecutive cycles of synchronized E high (saturating at 255); strobe = cycle where synchronized E is 0 and was 1 the prior cycle.
REQ-018 SHALL, on a strobe with count < E_MIN_CYCLES, discard the strobe, set o_glitch, and leave nibble state unchanged.
REQ-019 SHALL, on an accepted strobe, capture synchronized RS and D7..D4 from the last E-high cycle.
REQ-020 SHALL, in 8-bit mode (o_mode4=0), form byte = {D7..D4, 4'b0000} from each accepted strobe (D3..D0 unconnected, read 0) and complete it immediately.
REQ-021 SHALL, in 4-bit mode, run states HI_WAIT -> LO_WAIT -> HI_WAIT: HI_WAIT strobe stores high nibble and RS; LO_WAIT strobe completes byte = {stored high, current nibble} with RS from the high-nibble strobe.
REQ-022 SHALL switch to 4-bit mode when an 8-bit-mode completed byte has RS=0 and byte[7:4]=4'b0010; switch effective for the next strobe, state HI_WAIT.
REQ-023 SHALL switch to 8-bit mode when a 4-bit-mode completed byte has RS=0 and byte[7:4]=4'b0011 (function set DL=1); effective for the next strobe.
REQ-024 SHALL push every completed byte (including mode-switch commands) with its RS into the FIFO; mode switching never suppresses output.
REQ-025 SHALL produce o_valid high exactly 2 i_clk cycles after the strobe cycle that completes a byte, FIFO previously empty and no pop.
REQ-026 SHALL, when a byte completes with FIFO full, drop the new byte, keep FIFO contents, set o_overflow; a pop in the same cycle frees space, so no overflow then.
REQ-027 SHALL pop the head on o_valid & i_ready; push and pop in the same cycle both take effect; o_byte/o_rs stable while o_valid & ~i_ready.
REQ-028 SHALL hold o_byte and o_rs at 0 when o_valid is low.
REQ-029 SHALL clear o_overflow and o_glitch only by reset.

Reset
REQ-030 SHALL, while i_rst_n low, asynchronously force: synchronizers 0, E counter 0, FIFO empty, o_valid 0, o_byte 8'h00, o_rs 0, o_mode4 0, state HI_WAIT, o_overflow 0, o_glitch 0.
REQ-031 SHALL discard any half-received 4-bit byte on reset; reset deassertion mid-E-pulse SHALL NOT generate a strobe (E history reset to 0).
REQ-032 SHALL require reset deassertion synchronous to i_clk (external synchronizer); first strobe possible SYNC_STAGES+1 cycles after deassertion.

Verification
REQ-033 Init: after reset, four RS=0 strobes with nibbles 3,3,3,2 (E high 10 cycles) -> bytes 0x30,0x30,0x30,0x20, o_mode4=1 after fourth.
REQ-034 4-bit data: in 4-bit mode, RS=1 nibbles 4 then 1 -> one byte 0x41, o_rs=1, o_valid 2 cycles after second strobe.
REQ-035 Glitch: E high 3 cycles (E_MIN_CYCLES=8) with nibble 5 -> no byte, o_glitch=1, next valid pair 6,5 yields 0x65.
REQ-036 Overflow: i_ready=0, 5 bytes 0x11..0x55 (depth 4) -> FIFO holds 0x11..0x44, o_overflow=1; then i_ready=1 pops 0x11,0x22,0x33,0x44 in order.
REQ-037 Mode back: in 4-bit mode, RS=0 byte 0x38 -> o_mode4=0; next single strobe nibble 0xC -> byte 0xC0.
REQ-038 Reset mid-byte: high nibble 7 received, i_rst_n pulsed low, then nibbles 3,2 in 8-bit mode -> bytes 0x30,0x20, no 0x7x byte.
